// File: rtl/param_fifo_pkg.sv
// Shared helpers for param_fifo: address-width function and parameter legality checks.
package param_fifo_pkg;

    // ceil(log2(n)); returns 0 for n <= 1
    function automatic int unsigned width_of(input int unsigned n);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

    function automatic bit is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

    function automatic bit fifo_params_legal(
        input int unsigned width,
        input int unsigned depth,
        input int unsigned af_level,
        input int unsigned ae_level
    );
        return (width >= 1) && (depth >= 2) && is_pow2(depth) &&
               (af_level >= 1) && (af_level <= depth) && (ae_level <= depth - 1);
    endfunction

endpackage

// File: rtl/param_fifo_ram.sv
// DEPTH x WIDTH storage: synchronous write port, asynchronous read port, no reset.
module fifo_ram #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/param_fifo.sv
// Synchronous show-ahead FIFO with registered status, almost-full/empty thresholds
// and sticky overflow/underflow flags.
module param_fifo
    import param_fifo_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      io_clear,
    input  logic [WIDTH-1:0]          io_din,
    input  logic                      io_push,
    input  logic                      io_pop,
    output logic [WIDTH-1:0]          io_dout,
    output logic                      io_empty,
    output logic                      io_full,
    output logic [width_of(DEPTH):0]  io_count,
    output logic                      io_almost_full,
    output logic                      io_almost_empty,
    output logic                      io_overflow,
    output logic                      io_underflow
);

    localparam int unsigned AW        = width_of(DEPTH);
    localparam logic [AW:0] ONE       = (AW+1)'(1);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_CNT    = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_CNT    = (AW+1)'(AE_LEVEL);

    if (!fifo_params_legal(WIDTH, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
        $error("param_fifo: illegal WIDTH/DEPTH/AF_LEVEL/AE_LEVEL combination");
    end

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] count_q, count_d;
    logic        empty_q, empty_d;
    logic        full_q, full_d;
    logic        af_q, af_d;
    logic        ae_q, ae_d;
    logic        ovf_q, ovf_d;
    logic        udf_q, udf_d;
    logic        pop_ok;
    logic        push_ok;
    logic        ram_we;

    always_comb begin
        pop_ok   = io_pop & ~empty_q;
        push_ok  = io_push & (~full_q | pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;

        if (io_clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            // pointers carry a wrap bit, so plain increment wraps modulo 2*DEPTH
            if (push_ok) wr_ptr_d = wr_ptr_q + ONE;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + ONE;
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + ONE;
                2'b01:   count_d = count_q - ONE;
                default: count_d = count_q;
            endcase
            if (io_push & ~push_ok) ovf_d = 1'b1;
            if (io_pop & ~pop_ok)   udf_d = 1'b1;
        end

        // status derives from the next count so it is valid right after the edge
        empty_d = (count_d == '0);
        full_d  = (count_d == DEPTH_CNT);
        af_d    = (count_d >= AF_CNT);
        ae_d    = (count_d <= AE_CNT);
    end

    assign ram_we = push_ok & ~io_clear & reset;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (io_din),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (io_dout)
    );

    assign io_empty        = empty_q;
    assign io_full         = full_q;
    assign io_count        = count_q;
    assign io_almost_full  = af_q;
    assign io_almost_empty = ae_q;
    assign io_overflow     = ovf_q;
    assign io_underflow    = udf_q;

endmodule

// File: tb/tb_param_fifo.sv
// Bench for param_fifo (WIDTH=8, DEPTH=4, AF=3, AE=1): directed scenarios plus random traffic vs a queue model.
module tb_param_fifo;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int AF = 3;
    localparam int AE = 1;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         io_clear = 1'b0;
    logic [W-1:0] io_din = '0;
    logic         io_push = 1'b0;
    logic         io_pop = 1'b0;
    logic [W-1:0] io_dout;
    logic         io_empty;
    logic         io_full;
    logic [2:0]   io_count;
    logic         io_almost_full;
    logic         io_almost_empty;
    logic         io_overflow;
    logic         io_underflow;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    logic [W-1:0] mq[$];
    bit           m_ovf = 1'b0;
    bit           m_udf = 1'b0;

    param_fifo #(
        .WIDTH    (W),
        .DEPTH    (D),
        .AF_LEVEL (AF),
        .AE_LEVEL (AE)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .io_clear        (io_clear),
        .io_din          (io_din),
        .io_push         (io_push),
        .io_pop          (io_pop),
        .io_dout         (io_dout),
        .io_empty        (io_empty),
        .io_full         (io_full),
        .io_count        (io_count),
        .io_almost_full  (io_almost_full),
        .io_almost_empty (io_almost_empty),
        .io_overflow     (io_overflow),
        .io_underflow    (io_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue plus two sticky bits, updated on every rising edge.
    always @(posedge clk) begin
        bit pop_ok;
        bit push_ok;
        if (!reset || io_clear) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            pop_ok  = io_pop && (mq.size() > 0);
            push_ok = io_push && ((mq.size() < D) || pop_ok);
            if (pop_ok)  void'(mq.pop_front());
            if (push_ok) mq.push_back(io_din);
            if (io_push && !push_ok) m_ovf = 1'b1;
            if (io_pop && !pop_ok)   m_udf = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_count", 32'(io_count), 32'(mq.size()));
            check("model_empty", 32'(io_empty), 32'(mq.size() == 0));
            check("model_full", 32'(io_full), 32'(mq.size() == D));
            check("model_almost_full", 32'(io_almost_full), 32'(mq.size() >= AF));
            check("model_almost_empty", 32'(io_almost_empty), 32'(mq.size() <= AE));
            check("model_overflow", 32'(io_overflow), 32'(m_ovf));
            check("model_underflow", 32'(io_underflow), 32'(m_udf));
            if (mq.size() > 0) check("model_dout", 32'(io_dout), 32'(mq[0]));
        end
    end

    task automatic cyc(input logic rn, input logic clr, input logic ps, input logic pp,
                       input logic [W-1:0] d);
        reset    = rn;
        io_clear = clr;
        io_push  = ps;
        io_pop   = pp;
        io_din   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] d);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, d);
    endtask

    task automatic pop();
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    endtask

    task automatic idle();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        logic [W-1:0] seq [4];
        logic [W-1:0] d;
        int           push_pct;

        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk_en = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'hEE);
        check("rst_count", 32'(io_count), 0);
        check("rst_empty", 32'(io_empty), 1);
        check("rst_full", 32'(io_full), 0);
        check("rst_almost_empty", 32'(io_almost_empty), 1);
        check("rst_almost_full", 32'(io_almost_full), 0);
        check("rst_overflow", 32'(io_overflow), 0);
        check("rst_underflow", 32'(io_underflow), 0);

        // fill and drain in order
        seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;
        for (int i = 0; i < 4; i++) push(seq[i]);
        check("fill_full", 32'(io_full), 1);
        check("fill_count", 32'(io_count), 4);
        for (int i = 0; i < 4; i++) begin
            check("drain_dout", 32'(io_dout), 32'(seq[i]));
            pop();
        end
        check("drain_empty", 32'(io_empty), 1);

        // overflow when full, then push+pop when full
        for (int i = 1; i <= 4; i++) push(W'(i));
        push(8'h55);
        check("ovf_count", 32'(io_count), 4);
        check("ovf_flag", 32'(io_overflow), 1);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'h66);
        check("full_pushpop_count", 32'(io_count), 4);
        for (int i = 0; i < 3; i++) pop();
        check("full_pushpop_last", 32'(io_dout), 32'h66);
        pop();

        // push+pop when empty
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'hA5);
        check("empty_pushpop_udf", 32'(io_underflow), 1);
        check("empty_pushpop_count", 32'(io_count), 1);
        check("empty_pushpop_dout", 32'(io_dout), 32'hA5);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        check("clr_ovf", 32'(io_overflow), 0);
        check("clr_udf", 32'(io_underflow), 0);

        // clear at count 3 with a push in the same cycle
        push(8'hC1); push(8'hC2); push(8'hC3);
        check("pre_clr_count", 32'(io_count), 3);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h77);
        check("clr_count", 32'(io_count), 0);
        check("clr_empty", 32'(io_empty), 1);
        push(8'h88);
        check("clr_nostore_count", 32'(io_count), 1);
        check("clr_nostore_dout", 32'(io_dout), 32'h88);
        pop();

        // reset at count 3 with a sticky flag set and a push in flight
        for (int i = 0; i < 4; i++) push(8'hD0 + W'(i));
        push(8'hDF);
        pop();
        check("pre_rst_count", 32'(io_count), 3);
        check("pre_rst_ovf", 32'(io_overflow), 1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'hBB);
        check("rst3_count", 32'(io_count), 0);
        check("rst3_empty", 32'(io_empty), 1);
        check("rst3_ovf", 32'(io_overflow), 0);
        push(8'h99);
        check("rst3_nostore_dout", 32'(io_dout), 32'h99);
        check("rst3_nostore_count", 32'(io_count), 1);
        pop();

        // ten interleaved push/pop pairs, pointers wrap several times
        for (int i = 0; i < 10; i++) begin
            d = 8'h30 + W'(i * 7);
            push(d);
            check("wrap_dout", 32'(io_dout), 32'(d));
            pop();
        end
        check("wrap_ovf", 32'(io_overflow), 0);
        check("wrap_udf", 32'(io_underflow), 0);
        check("wrap_empty", 32'(io_empty), 1);

        // almost-full / almost-empty thresholds
        push(8'h01); push(8'h02);
        check("af_at2", 32'(io_almost_full), 0);
        check("ae_at2", 32'(io_almost_empty), 0);
        push(8'h03);
        check("af_at3", 32'(io_almost_full), 1);
        pop();
        check("ae_at2_drain", 32'(io_almost_empty), 0);
        pop();
        check("ae_at1", 32'(io_almost_empty), 1);
        check("af_at1", 32'(io_almost_full), 0);
        pop();

        // random traffic with varying push bias, occasional clear and reset
        for (int seg = 0; seg < 4; seg++) begin
            push_pct = (seg == 0) ? 75 : (seg == 1) ? 25 : 50;
            for (int i = 0; i < 500; i++) begin
                cyc(($urandom_range(0, 199) != 0),
                    ($urandom_range(0, 63) == 0),
                    ($urandom_range(0, 99) < push_pct),
                    ($urandom_range(0, 99) >= push_pct - 10 && $urandom_range(0, 1) == 1),
                    W'($urandom_range(0, 255)));
            end
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
